mem_arbiter: RTL and testbench

Sequencer and arbiter that shares the single-port unified memory between the fetch stage (instruction reads) and the memory stage (data loads/stores). Each access is accepted through a request/done handshake and held on the memory for a fixed latency. The result is returned on the owning port. Requesters receive stall outputs that the pipeline control uses to freeze the stages upstream. Flushes cancel in-flight instruction results without corrupting the memory.

---
 rtl/mem_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
//
// Shares one single-port unified memory between the fetch stage (instruction
// reads) and the memory stage (data loads and stores). A request is granted
// from IDLE, then held on the memory for LATENCY cycles in ACCESS. The result
// is returned on the port that owns the access, together with a one-cycle
// done pulse. A flush cancels the result of an in-flight fetch, but the
// memory access itself still runs its full length.
//
// Parameters
//   LATENCY  cycles an access occupies the memory (1..8)
//   AW       address width
//   DW       data width
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous, active-low reset
//   if_req     fetch read request (level)
//   if_addr    fetch address
//   if_rdata   fetch read data (registered)
//   if_done    one-cycle fetch completion pulse
//   if_stall   fetch must hold
//   dm_req     data request (level)
//   dm_wr      1 = store, 0 = load
//   dm_addr    data address
//   dm_wdata   store data
//   dm_rdata   load data (registered)
//   dm_done    one-cycle data completion pulse (loads and stores)
//   dm_stall   memory stage must hold
//   flush      pipeline flush, affects the fetch port only
//   mem_en     memory enable
//   mem_wr     memory write strobe
//   mem_addr   memory address
//   mem_wdata  memory write data
//   mem_rdata  memory read data, valid in the final access cycle
//   busy       access in progress

module mem_arbiter #(
  parameter int LATENCY = 2,
  parameter int AW      = 16,
  parameter int DW      = 16
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  output logic          if_stall,

  input  logic          dm_req,
  input  logic          dm_wr,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_done,
  output logic          dm_stall,

  input  logic          flush,

  output logic          mem_en,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,

  output logic          busy
);

  // The down-counter needs at least one bit even when LATENCY is 1.
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  typedef enum logic {
    PORT_IF,
    PORT_DM
  } port_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic            kill;
  port_t           last_grant;
  port_t           owner;
  logic [AW-1:0]   lat_addr;
  logic [DW-1:0]   lat_wdata;
  logic            lat_wr;

  logic            if_elig;
  logic            dm_elig;
  logic            grant_if;
  logic            grant_dm;
  logic            final_cycle;
  logic            kill_now;

  // A port whose done is high this cycle has just been served; masking its
  // request here is what stops the same request being granted twice.
  assign if_elig = if_req & ~if_done & ~flush;
  assign dm_elig = dm_req & ~dm_done;

  // A flush in the final cycle must cancel the result too, so the kill
  // decision looks at the live flush as well as the sticky flag.
  assign kill_now = kill | (flush & (owner == PORT_IF));

  // State register; an asynchronous reset drops mem_en and busy at once
  // because both are decoded straight from the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and grant decode. On a conflict the port that was not
  // granted most recently wins, so neither requester can starve.
  always_comb begin
    state_nxt   = state;
    grant_if    = 1'b0;
    grant_dm    = 1'b0;
    final_cycle = 1'b0;
    case (state)
      IDLE: begin
        if (dm_elig && (!if_elig || (last_grant == PORT_IF))) begin
          grant_dm  = 1'b1;
          state_nxt = ACCESS;
        end else if (if_elig) begin
          grant_if  = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          final_cycle = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Access bookkeeping: latch the granted request, count the access down,
  // and on the final cycle deliver the result to the owning port. The done
  // pulses default low so each lasts exactly one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      kill       <= 1'b0;
      last_grant <= PORT_IF;
      owner      <= PORT_IF;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_wr     <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      if_done    <= 1'b0;
      dm_done    <= 1'b0;
    end else begin
      if_done <= 1'b0;
      dm_done <= 1'b0;
      if (grant_dm) begin
        lat_addr   <= dm_addr;
        lat_wdata  <= dm_wdata;
        lat_wr     <= dm_wr;
        owner      <= PORT_DM;
        last_grant <= PORT_DM;
        cnt        <= CNT_LOAD;
      end else if (grant_if) begin
        lat_addr   <= if_addr;
        lat_wdata  <= '0;
        lat_wr     <= 1'b0;
        owner      <= PORT_IF;
        last_grant <= PORT_IF;
        cnt        <= CNT_LOAD;
      end else if (state == ACCESS) begin
        if (final_cycle) begin
          kill <= 1'b0;
          if (owner == PORT_DM) begin
            dm_done <= 1'b1;
            if (!lat_wr) begin
              dm_rdata <= mem_rdata;
            end
          end else if (!kill_now) begin
            if_done  <= 1'b1;
            if_rdata <= mem_rdata;
          end
        end else begin
          cnt <= cnt - 1'b1;
          if (kill_now) begin
            kill <= 1'b1;
          end
        end
      end
    end
  end

  // The memory sees the latched request for the whole access, so the
  // requesters' inputs are never re-sampled once a grant has been made.
  assign busy      = (state == ACCESS);
  assign mem_en    = busy;
  assign mem_wr    = busy & lat_wr;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;

  assign if_stall  = if_req & ~if_done;
  assign dm_stall  = dm_req & ~dm_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//
// Bench for mem_arbiter with LATENCY=2. A behavioural memory answers the
// arbiter's memory port. Each scenario task pushes the completions it expects
// onto a scoreboard queue; a monitor pops an entry whenever a done pulse
// appears and checks the port and returned data. Cycle-level timing is
// checked inline in each task.

module tb_mem_arbiter;

  localparam int LAT = 2;
  localparam int AW  = 16;
  localparam int DW  = 16;

  logic          clk;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_done;
  logic          if_stall;
  logic          dm_req;
  logic          dm_wr;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_done;
  logic          dm_stall;
  logic          flush;
  logic          mem_en;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  int vectors;
  int miscompares;

  typedef struct {
    logic          is_dm;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  logic [DW-1:0] mem [0:65535];

  mem_arbiter #(
    .LATENCY(LAT),
    .AW     (AW),
    .DW     (DW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_done  (if_done),
    .if_stall (if_stall),
    .dm_req   (dm_req),
    .dm_wr    (dm_wr),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata),
    .dm_done  (dm_done),
    .dm_stall (dm_stall),
    .flush    (flush),
    .mem_en   (mem_en),
    .mem_wr   (mem_wr),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy     (busy)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port memory: combinational read, clocked write.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_en && mem_wr) mem[mem_addr] <= mem_wdata;
  end

  // Completion monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst && (if_done || dm_done)) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL sb_unexpected_done: got if_done=%b dm_done=%b, expected no completion", if_done, dm_done);
      end else begin
        mon_e = sb.pop_front();
        if (dm_done !== mon_e.is_dm || if_done === dm_done) begin
          miscompares++;
          $display("[TB] FAIL sb_port: got if_done=%b dm_done=%b, expected dm=%b", if_done, dm_done, mon_e.is_dm);
        end else if (mon_e.is_dm && dm_rdata !== mon_e.data) begin
          miscompares++;
          $display("[TB] FAIL sb_dm_rdata: got %h expected %h", dm_rdata, mon_e.data);
        end else if (!mon_e.is_dm && if_rdata !== mon_e.data) begin
          miscompares++;
          $display("[TB] FAIL sb_if_rdata: got %h expected %h", if_rdata, mon_e.data);
        end
      end
    end
  end

  task automatic check_sb_empty(input string name);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL %s_sb_drain: got %0d pending completions, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if ({mem_en, mem_wr, busy, if_done, dm_done, if_stall, dm_stall} !== 7'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl: got en=%b wr=%b busy=%b ifd=%b dmd=%b, expected all 0", mem_en, mem_wr, busy, if_done, dm_done);
    end
    vectors++;
    if (mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_mem_bus: got addr=%h wdata=%h expected 0000 0000", mem_addr, mem_wdata);
    end
    vectors++;
    if (if_rdata !== 16'h0 || dm_rdata !== 16'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_rdata: got if=%h dm=%h expected 0000 0000", if_rdata, dm_rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_fetch();
    logic exp_en, exp_stall, exp_done;
    mem[16'h0010] = 16'h1234;
    sb.push_back('{is_dm: 1'b0, data: 16'h1234});
    for (int c = 0; c <= 5; c++) begin
      if_req  = (c <= 3);
      if_addr = 16'h0010;
      @(negedge clk);
      exp_en    = (c == 1 || c == 2);
      exp_stall = (c <= 2);
      exp_done  = (c == 3);
      vectors++;
      if (mem_en !== exp_en || busy !== exp_en) begin
        miscompares++;
        $display("[TB] FAIL fetch_mem_en c=%0d: got en=%b busy=%b expected %b", c, mem_en, busy, exp_en);
      end
      if (exp_en) begin
        vectors++;
        if (mem_addr !== 16'h0010 || mem_wr !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL fetch_mem_bus c=%0d: got addr=%h wr=%b expected 0010 0", c, mem_addr, mem_wr);
        end
      end
      vectors++;
      if (if_stall !== exp_stall) begin
        miscompares++;
        $display("[TB] FAIL fetch_stall c=%0d: got %b expected %b", c, if_stall, exp_stall);
      end
      vectors++;
      if (if_done !== exp_done) begin
        miscompares++;
        $display("[TB] FAIL fetch_done c=%0d: got %b expected %b", c, if_done, exp_done);
      end
      @(posedge clk); #1;
    end
    if_req = 1'b0;
    check_sb_empty("fetch");
  endtask

  task automatic test_store_load();
    logic exp_done, exp_wr;
    sb.push_back('{is_dm: 1'b1, data: 16'h0000});
    sb.push_back('{is_dm: 1'b1, data: 16'hBEEF});
    for (int c = 0; c <= 9; c++) begin
      dm_req   = (c <= 3) || (c >= 5 && c <= 8);
      dm_wr    = (c <= 3);
      dm_addr  = 16'h0040;
      dm_wdata = 16'hBEEF;
      @(negedge clk);
      exp_done = (c == 3 || c == 8);
      exp_wr   = (c == 1 || c == 2);
      vectors++;
      if (dm_done !== exp_done) begin
        miscompares++;
        $display("[TB] FAIL stld_done c=%0d: got %b expected %b", c, dm_done, exp_done);
      end
      vectors++;
      if (mem_wr !== exp_wr) begin
        miscompares++;
        $display("[TB] FAIL stld_mem_wr c=%0d: got %b expected %b", c, mem_wr, exp_wr);
      end
      if (c == 4) begin
        vectors++;
        if (mem[16'h0040] !== 16'hBEEF) begin
          miscompares++;
          $display("[TB] FAIL stld_mem_word: got %h expected beef", mem[16'h0040]);
        end
      end
      @(posedge clk); #1;
    end
    dm_req = 1'b0;
    dm_wr  = 1'b0;
    check_sb_empty("stld");
  endtask

  task automatic test_round_robin();
    logic exp_en, exp_if_done, exp_dm_done;
    logic [AW-1:0] exp_addr;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    mem[16'h0020] = 16'hAAAA;
    mem[16'h0030] = 16'h5555;
    sb.push_back('{is_dm: 1'b1, data: 16'h5555});
    sb.push_back('{is_dm: 1'b0, data: 16'hAAAA});
    sb.push_back('{is_dm: 1'b1, data: 16'h5555});
    sb.push_back('{is_dm: 1'b0, data: 16'hAAAA});
    for (int c = 0; c <= 14; c++) begin
      if_req  = (c <= 12);
      if_addr = 16'h0020;
      dm_req  = (c <= 11);
      dm_wr   = 1'b0;
      dm_addr = 16'h0030;
      @(negedge clk);
      exp_en      = (c % 3 != 0) && (c <= 11);
      exp_dm_done = (c == 3 || c == 9);
      exp_if_done = (c == 6 || c == 12);
      exp_addr    = (c <= 2 || (c >= 7 && c <= 8)) ? 16'h0030 : 16'h0020;
      vectors++;
      if (mem_en !== exp_en) begin
        miscompares++;
        $display("[TB] FAIL rr_mem_en c=%0d: got %b expected %b", c, mem_en, exp_en);
      end
      if (exp_en) begin
        vectors++;
        if (mem_addr !== exp_addr) begin
          miscompares++;
          $display("[TB] FAIL rr_mem_addr c=%0d: got %h expected %h", c, mem_addr, exp_addr);
        end
      end
      vectors++;
      if (if_done !== exp_if_done || dm_done !== exp_dm_done) begin
        miscompares++;
        $display("[TB] FAIL rr_done c=%0d: got if=%b dm=%b expected if=%b dm=%b", c, if_done, dm_done, exp_if_done, exp_dm_done);
      end
      @(posedge clk); #1;
    end
    check_sb_empty("rr");
  endtask

  task automatic test_flush_fetch();
    logic exp_en, exp_dm_done;
    logic [AW-1:0] exp_addr;
    mem[16'h0050] = 16'h7777;
    mem[16'h0060] = 16'h9999;
    sb.push_back('{is_dm: 1'b1, data: 16'h9999});
    for (int c = 0; c <= 8; c++) begin
      if_req  = (c <= 3);
      if_addr = 16'h0050;
      dm_req  = (c >= 1 && c <= 6);
      dm_wr   = 1'b0;
      dm_addr = 16'h0060;
      flush   = (c == 2);
      @(negedge clk);
      exp_en      = (c == 1 || c == 2 || c == 4 || c == 5);
      exp_addr    = (c <= 2) ? 16'h0050 : 16'h0060;
      exp_dm_done = (c == 6);
      vectors++;
      if (mem_en !== exp_en) begin
        miscompares++;
        $display("[TB] FAIL flush_mem_en c=%0d: got %b expected %b", c, mem_en, exp_en);
      end
      if (exp_en) begin
        vectors++;
        if (mem_addr !== exp_addr) begin
          miscompares++;
          $display("[TB] FAIL flush_mem_addr c=%0d: got %h expected %h", c, mem_addr, exp_addr);
        end
      end
      vectors++;
      if (if_done !== 1'b0 || dm_done !== exp_dm_done) begin
        miscompares++;
        $display("[TB] FAIL flush_done c=%0d: got if=%b dm=%b expected if=0 dm=%b", c, if_done, dm_done, exp_dm_done);
      end
      @(posedge clk); #1;
    end
    flush = 1'b0;
    vectors++;
    if (if_rdata !== 16'hAAAA) begin
      miscompares++;
      $display("[TB] FAIL flush_if_rdata_hold: got %h expected aaaa", if_rdata);
    end
    check_sb_empty("flush");
  endtask

  task automatic test_flush_store();
    logic exp_done;
    sb.push_back('{is_dm: 1'b1, data: 16'h9999});
    for (int c = 0; c <= 5; c++) begin
      dm_req   = (c <= 3);
      dm_wr    = 1'b1;
      dm_addr  = 16'h0070;
      dm_wdata = 16'hCAFE;
      flush    = (c <= 4);
      @(negedge clk);
      exp_done = (c == 3);
      vectors++;
      if (dm_done !== exp_done) begin
        miscompares++;
        $display("[TB] FAIL fstore_done c=%0d: got %b expected %b", c, dm_done, exp_done);
      end
      @(posedge clk); #1;
    end
    flush = 1'b0;
    dm_wr = 1'b0;
    vectors++;
    if (mem[16'h0070] !== 16'hCAFE) begin
      miscompares++;
      $display("[TB] FAIL fstore_mem_word: got %h expected cafe", mem[16'h0070]);
    end
    check_sb_empty("fstore");
  endtask

  task automatic test_done_mask();
    logic exp_en, exp_done;
    sb.push_back('{is_dm: 1'b1, data: 16'h9999});
    sb.push_back('{is_dm: 1'b1, data: 16'h9999});
    for (int c = 0; c <= 9; c++) begin
      dm_req  = (c <= 7);
      dm_wr   = 1'b0;
      dm_addr = 16'h0060;
      @(negedge clk);
      exp_en   = (c == 1 || c == 2 || c == 5 || c == 6);
      exp_done = (c == 3 || c == 7);
      vectors++;
      if (mem_en !== exp_en || busy !== exp_en) begin
        miscompares++;
        $display("[TB] FAIL mask_mem_en c=%0d: got en=%b busy=%b expected %b", c, mem_en, busy, exp_en);
      end
      vectors++;
      if (dm_done !== exp_done) begin
        miscompares++;
        $display("[TB] FAIL mask_done c=%0d: got %b expected %b", c, dm_done, exp_done);
      end
      @(posedge clk); #1;
    end
    check_sb_empty("mask");
  endtask

  task automatic test_reset_mid_access();
    logic exp_en, exp_done;
    if_req  = 1'b1;
    if_addr = 16'h0010;
    @(posedge clk); #1;
    vectors++;
    if (mem_en !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rmid_started: got en=%b busy=%b expected 1 1", mem_en, busy);
    end
    #1 rst = 1'b0;
    #1;
    vectors++;
    if (mem_en !== 1'b0 || busy !== 1'b0 || if_done !== 1'b0 || dm_done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rmid_async: got en=%b busy=%b ifd=%b dmd=%b expected all 0", mem_en, busy, if_done, dm_done);
    end
    @(posedge clk); #1;
    vectors++;
    if (if_rdata !== 16'h0 || dm_rdata !== 16'h0 || mem_addr !== 16'h0) begin
      miscompares++;
      $display("[TB] FAIL rmid_cleared: got if=%h dm=%h addr=%h expected 0000", if_rdata, dm_rdata, mem_addr);
    end
    rst = 1'b1;
    sb.push_back('{is_dm: 1'b0, data: 16'h1234});
    for (int c = 0; c <= 4; c++) begin
      if_req = (c <= 3);
      @(negedge clk);
      exp_en   = (c == 1 || c == 2);
      exp_done = (c == 3);
      vectors++;
      if (mem_en !== exp_en || if_done !== exp_done) begin
        miscompares++;
        $display("[TB] FAIL rmid_regrant c=%0d: got en=%b done=%b expected en=%b done=%b", c, mem_en, if_done, exp_en, exp_done);
      end
      if (c == 0) begin
        @(posedge clk); #1;
        vectors++;
        if (mem_wr !== 1'b0 || mem_en !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL rmid_regrant_bus: got en=%b wr=%b expected 1 0", mem_en, mem_wr);
        end
      end else begin
        @(posedge clk); #1;
      end
    end
    check_sb_empty("rmid");
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst      = 1'b0;
    if_req   = 1'b0;
    if_addr  = '0;
    dm_req   = 1'b0;
    dm_wr    = 1'b0;
    dm_addr  = '0;
    dm_wdata = '0;
    flush    = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    $display("[TB] single fetch");
    test_single_fetch();
    $display("[TB] store then load");
    test_store_load();
    $display("[TB] conflict and round-robin");
    test_round_robin();
    $display("[TB] flush mid-fetch");
    test_flush_fetch();
    $display("[TB] flush during store");
    test_flush_store();
    $display("[TB] done masking");
    test_done_mask();
    $display("[TB] reset mid-access");
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
